imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader sitting directly upstream of the processor core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes them sequentially into instruction memory from address 0. When the load completes it releases the core by asserting `core_run`, which the top level uses to hold the core's `rst` until the program is in place.

## Interface
Parameters:
- `AW`, 10: instruction memory address width, giving 1024 words.
- `MAX_WORDS`, 1024: largest accepted word count; must be ≤ 2^AW.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_req`  in  1  synchronous restart pulse; aborts any load and returns to IDLE.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte; a byte transfers when `rx_valid & rx_ready` at the clock edge.
- `im_we`  out  1  one-cycle instruction memory write strobe.
- `im_addr`  out  AW  write address.
- `im_wdata`  out  16  write data.
- `words_loaded`  out  11  count of words written in the current load.
- `busy`  out  1  high in any state other than DONE or ERROR.
- `core_run`  out  1  high only in DONE; the core runs while this is high.
- `error`  out  1  high only in ERROR.

## Operation
- Stream format is: count_hi, count_lo, then N × (word_hi, word_lo), then [checksum]. N is a 16-bit word count.
- FSM states and transitions:
  - CNT_HI: accepting a byte latches it into count[15:8] and moves to CNT_LO.
  - CNT_LO: accepting a byte latches count[7:0]. If N=0 or N>MAX_WORDS, go to ERROR; otherwise go to DAT_HI.
  - DAT_HI: accepting a byte latches it into word[15:8] and moves to DAT_LO.
  - DAT_LO: accepting a byte registers a write with `im_wdata`={hi,lo} and `im_addr`=words_loaded, then increments words_loaded. If this was the N-th word, go to DONE (or CHK when checksum is compiled in); otherwise go to DAT_HI.
  - CHK: accepting a byte compares it with the running checksum; a match goes to DONE, a mismatch goes to ERROR.
  - DONE: holds; `rx_ready`=0.
  - ERROR: holds; `rx_ready`=0.
- `rx_ready` equals 1 in CNT_HI, CNT_LO, DAT_HI, DAT_LO and CHK; it is purely state-decoded.
- `load_req` is honoured from every state. The next state is CNT_HI, words_loaded clears, `core_run` and `error` drop, and the checksum clears.
- If `load_req` and a byte transfer occur in the same cycle, `load_req` wins and the byte is discarded. It still counts as consumed, because `rx_ready` was high.
- `im_addr` wraps at 2^AW, but it is never reached, because the MAX_WORDS check rejects such counts.
- Bytes are not buffered. Back-to-back transfers every cycle must be sustained.

## Timing
- Reset values: state=CNT_HI, `rx_ready`=1, `im_we`=0, `im_addr`=0, `im_wdata`=0, `words_loaded`=0, `busy`=1, `core_run`=0, `error`=0.
- `im_we` pulses for exactly one cycle, in the cycle after the word_lo transfer. `im_addr` and `im_wdata` are stable during that pulse and hold their values afterwards.
- Without checksum, `core_run` rises in the same cycle as the final `im_we` pulse. The core therefore sees the last word written on that edge.
- With checksum, `core_run` or `error` rises in the cycle after the checksum byte transfer.
- ERROR from a bad count rises in the cycle after the count_lo transfer.
- Asserting `rst` mid-load returns every output to its reset value immediately. Deassertion is consumed synchronously on the next edge.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CHK state is present.
  - The running checksum is the XOR of every data byte (count bytes excluded).
  - A trailing checksum byte is required; a mismatch leads to ERROR.
- Not defined:
  - The CHK state and the checksum register are absent.
  - The FSM goes DAT_LO → DONE after the N-th word, and no trailing byte is expected.

## Test plan
- Reset, then stream 00 02 12 34 AB CD back-to-back → im_we at addr 0 with data 0x1234 and at addr 1 with data 0xABCD, words_loaded=2, `core_run`=1, `rx_ready`=0.
- Count 00 00, and separately count 04 01 (1025) → `error`=1 the cycle after count_lo, `core_run`=0, and no `im_we` at any point.
- Checksum build, stream 00 01 5A A5 FF → DONE. Repeat with a final byte of 00 → ERROR, while the word is still written to addr 0.
- Send 00 03 and one word, then pulse `load_req` in the same cycle as a byte transfer → byte dropped, state CNT_HI, words_loaded=0. A fresh 00 01 BE EF then writes 0xBEEF at addr 0.
- Assert `rst` low mid-word → all outputs at reset values asynchronously; after release, a full 1-word load succeeds.
- Toggle `rx_valid` randomly during a 1024-word load → 1024 writes, last at addr 1023; `core_run` high in the same cycle as the last `im_we`.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 16-bit words written to instruction memory from address 0.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over the data bytes.
module imem_loader #(
    parameter int AW = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_req,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [15:0]   im_wdata,
    output logic [10:0]   words_loaded,
    output logic          busy,
    output logic          core_run,
    output logic          error
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK, DONE, ERR} state_t;
    logic [7:0] chk;
`else
    typedef enum logic [2:0] {CNT_HI, CNT_LO, DAT_HI, DAT_LO, DONE, ERR} state_t;
`endif
    state_t state;
    logic [15:0] cnt;
    logic [7:0] hi;
    logic [15:0] cnt_n;
    logic last;
    assign cnt_n = {cnt[15:8], rx_data};
    assign last = {5'b0, words_loaded} + 16'd1 == cnt;
    // Status outputs are pure state decodes so reset forces them immediately.
    assign rx_ready = state != DONE && state != ERR;
    assign busy = state != DONE && state != ERR;
    assign core_run = state == DONE;
    assign error = state == ERR;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CNT_HI;
            cnt <= '0;
            hi <= '0;
            im_we <= 1'b0;
            im_addr <= '0;
            im_wdata <= '0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk <= '0;
`endif
        end else begin
            im_we <= 1'b0;
            if (load_req) begin
                state <= CNT_HI;
                words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                chk <= '0;
`endif
            end else if (rx_valid && rx_ready) begin
                case (state)
                    CNT_HI: begin
                        cnt[15:8] <= rx_data;
                        state <= CNT_LO;
                    end
                    CNT_LO: begin
                        cnt[7:0] <= rx_data;
                        state <= (cnt_n == 16'd0 || 32'(cnt_n) > MAX_WORDS) ? ERR : DAT_HI;
                    end
                    DAT_HI: begin
                        hi <= rx_data;
                        state <= DAT_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk <= chk ^ rx_data;
`endif
                    end
                    DAT_LO: begin
                        im_we <= 1'b1;
                        im_addr <= words_loaded[AW-1:0];
                        im_wdata <= {hi, rx_data};
                        words_loaded <= words_loaded + 11'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk <= chk ^ rx_data;
                        state <= last ? CHK : DAT_HI;
`else
                        state <= last ? DONE : DAT_HI;
`endif
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    CHK: state <= rx_data == chk ? DONE : ERR;
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream loads checked against a word-list model of the loader.
module tb_imem_loader;
    logic clk = 0, rst = 0, load_req = 0, rx_valid = 0;
    logic [7:0] rx_data = 0;
    logic rx_ready, im_we, busy, core_run, error;
    logic [9:0] im_addr;
    logic [15:0] im_wdata;
    logic [10:0] words_loaded;
    int checks = 0, failures = 0;
    logic [15:0] words [1024];
    logic [9:0] got_a [$];
    logic [15:0] got_d [$];
    logic got_run [$];

    imem_loader dut (
        .clk(clk), .rst(rst), .load_req(load_req), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .words_loaded(words_loaded), .busy(busy), .core_run(core_run), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (im_we) begin
        got_a.push_back(im_addr);
        got_d.push_back(im_wdata);
        got_run.push_back(core_run);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_a.delete();
        got_d.delete();
        got_run.delete();
    endtask

    task automatic send(input logic [7:0] b, input bit rnd);
        if (rnd) repeat ($urandom_range(0, 2)) begin
            rx_valid = 0;
            tick();
        end
        rx_data = b;
        rx_valid = 1;
        tick();
        rx_valid = 0;
    endtask

    task automatic pulse_load();
        load_req = 1;
        tick();
        load_req = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rx_ready"}, rx_ready, 1);
        check({tag, "_im_we"}, im_we, 0);
        check({tag, "_im_addr"}, im_addr, 0);
        check({tag, "_im_wdata"}, im_wdata, 0);
        check({tag, "_words"}, words_loaded, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_core_run"}, core_run, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // Model: a good load writes words[i] at address i for i < n, then ends in DONE.
    task automatic run_load(input int n, input bit rnd, input bit pulse, input bit corrupt);
        logic [7:0] x;
        bit ok;
        x = 0;
        ok = 1;
        if (pulse) pulse_load();
        clear_log();
        send(8'(n >> 8), rnd);
        send(8'(n), rnd);
        for (int i = 0; i < n; i++) begin
            send(words[i][15:8], rnd);
            send(words[i][7:0], rnd);
            x = x ^ words[i][15:8] ^ words[i][7:0];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ok = !corrupt;
        send(corrupt ? ~x : x, rnd);
        check("chk_run_rise", core_run, ok);
        check("chk_err_rise", error, !ok);
`else
        check("we_at_done", im_we, 1);
        check("run_at_done", core_run, 1);
`endif
        repeat (3) tick();
        check("n_writes", got_a.size(), n);
        for (int i = 0; i < got_a.size() && i < n; i++) begin
            check("wr_addr", got_a[i], i);
            check("wr_data", got_d[i], words[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
            check("run_during_we", got_run[i], 0);
`else
            check("run_during_we", got_run[i], i == n - 1);
`endif
        end
        check("words_loaded", words_loaded, n);
        check("core_run", core_run, ok);
        check("error", error, !ok);
        check("rx_ready_end", rx_ready, 0);
        check("busy_end", busy, 0);
    endtask

    task automatic bad_count(input logic [7:0] h, input logic [7:0] l);
        pulse_load();
        clear_log();
        send(h, 0);
        send(l, 0);
        check("bad_err_rise", error, 1);
        check("bad_core_run", core_run, 0);
        check("bad_rx_ready", rx_ready, 0);
        repeat (3) tick();
        check("bad_no_we", got_a.size(), 0);
        check("bad_err_hold", error, 1);
    endtask

    initial begin
        #1;
        check_reset("rst");
        #12 rst = 1;
        tick();
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        run_load(2, 0, 0, 0);
        bad_count(8'h00, 8'h00);
        bad_count(8'h04, 8'h01);
`ifdef IMEM_LOADER_CHECKSUM_EN
        words[0] = 16'h5AA5;
        run_load(1, 0, 1, 0);
        run_load(1, 0, 1, 1);
`endif
        pulse_load();
        clear_log();
        send(8'h00, 0);
        send(8'h03, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        rx_data = 8'h33;
        rx_valid = 1;
        load_req = 1;
        tick();
        rx_valid = 0;
        load_req = 0;
        check("abort_words", words_loaded, 0);
        check("abort_ready", rx_ready, 1);
        check("abort_busy", busy, 1);
        words[0] = 16'hBEEF;
        run_load(1, 0, 0, 0);
        pulse_load();
        send(8'h00, 0);
        send(8'h02, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'h56, 0);
        #2 rst = 0;
        #1 check_reset("async");
        #2 rst = 1;
        tick();
        words[0] = 16'hC0DE;
        run_load(1, 0, 0, 0);
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) words[i] = 16'($urandom);
            run_load(n, 1, 1, 0);
        end
        for (int i = 0; i < 1024; i++) words[i] = 16'($urandom);
        run_load(1024, 1, 1, 0);
        if (got_a.size() > 0) check("last_addr", got_a[got_a.size() - 1], 1023);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
